// File: rtl/hs32_regport.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hs32_regport
//  Purpose  : Access port in front of the hs32 register file. Arbitrates
//             write-backs against operand fetches (writes win, with a
//             bounded-starvation guard for reads), sequences the registered
//             read, and holds the fetched operands behind a valid/ready
//             response.
//  Revision : 1.0  initial release
// ============================================================================
module hs32_regport #(
    parameter int WB_STALL_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    // write-back stream from execute
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_adr,
    input  logic [31:0] wb_data,
    // operand fetch stream from decode
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_rs1,
    input  logic [3:0]  req_rs2,
    // operand response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_op1,
    output logic [31:0] rsp_op2,
    // register file port
    output logic        rf_we,
    output logic [3:0]  rf_wadr,
    output logic [31:0] rf_din,
    output logic [3:0]  rf_radr1,
    output logic [3:0]  rf_radr2,
    input  logic [31:0] rf_dout1,
    input  logic [31:0] rf_dout2
);

    localparam int              c_CW        = (WB_STALL_MAX < 1) ? 1 : $clog2(WB_STALL_MAX + 1);
    localparam logic [c_CW-1:0] c_DEFER_MAX = c_CW'(WB_STALL_MAX);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_defer_cnt;
    logic [3:0]      r_radr1;
    logic [3:0]      r_radr2;
    logic [31:0]     r_op1;
    logic [31:0]     r_op2;
    logic            w_slot_free;
    logic            w_issue;
    logic            w_defer_inc;

    // Arbitration: a read may only start when the response slot is (or is
    // becoming) empty, and it beats a write only once the guard has expired.
    assign w_slot_free = (r_state == c_ST_IDLE) || ((r_state == c_ST_RESP) && rsp_ready);
    assign w_issue     = req_valid && w_slot_free && (!wb_valid || (r_defer_cnt == c_DEFER_MAX));
    assign w_defer_inc = req_valid && w_slot_free && wb_valid && !w_issue;

    assign req_ready = w_issue;
    assign wb_ready  = !w_issue;
    assign rf_we     = wb_valid && !w_issue;
    assign rf_wadr   = wb_adr;
    assign rf_din    = wb_data;

    // Addresses are presented live in the issue cycle and held afterwards so
    // the file keeps pointing at the same registers.
    assign rf_radr1  = w_issue ? req_rs1 : r_radr1;
    assign rf_radr2  = w_issue ? req_rs2 : r_radr2;

    assign rsp_valid = (r_state == c_ST_RESP);
    assign rsp_op1   = r_op1;
    assign rsp_op2   = r_op2;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the fetch sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_issue ? c_ST_FETCH : c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Held read addresses and operand capture; the file's registered output
    // is valid in the cycle after issue, which is exactly the FETCH cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_radr1 <= 4'd0;
            r_radr2 <= 4'd0;
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
        end else begin
            if (w_issue) begin
                r_radr1 <= req_rs1;
                r_radr2 <= req_rs2;
            end
            if (r_state == c_ST_FETCH) begin
                r_op1 <= rf_dout1;
                r_op2 <= rf_dout2;
            end
        end
    end

    // Starvation guard: counts cycles a ready-to-go fetch lost to a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_defer_cnt <= '0;
        end else if (w_issue || !req_valid) begin
            r_defer_cnt <= '0;
        end else if (w_defer_inc && (r_defer_cnt != c_DEFER_MAX)) begin
            r_defer_cnt <= r_defer_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs32_regport.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hs32_regport
//  Purpose  : Self-checking bench for hs32_regport. Surrounds the port with a
//             register file model, predicts arbitration and operand values
//             from a transaction-level model and checks them in a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hs32_regport;

    localparam int WB_STALL_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [3:0]  wb_adr = 4'd0;
    logic [31:0] wb_data = 32'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_rs1 = 4'd0;
    logic [3:0]  req_rs2 = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_op1;
    logic [31:0] rsp_op2;
    logic        rf_we;
    logic [3:0]  rf_wadr;
    logic [31:0] rf_din;
    logic [3:0]  rf_radr1;
    logic [3:0]  rf_radr2;
    logic [31:0] rf_dout1 = 32'd0;
    logic [31:0] rf_dout2 = 32'd0;

    always #5 clk = ~clk;

    hs32_regport #(.WB_STALL_MAX(WB_STALL_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_adr    (wb_adr),
        .wb_data   (wb_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op1   (rsp_op1),
        .rsp_op2   (rsp_op2),
        .rf_we     (rf_we),
        .rf_wadr   (rf_wadr),
        .rf_din    (rf_din),
        .rf_radr1  (rf_radr1),
        .rf_radr2  (rf_radr2),
        .rf_dout1  (rf_dout1),
        .rf_dout2  (rf_dout2)
    );

    // Register file: write at end of cycle, registered read only on non-write cycles.
    logic [31:0] rf_mem [16] = '{default: 32'h0};
    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_wadr] <= rf_din;
        end else begin
            rf_dout1 <= rf_mem[rf_radr1];
            rf_dout2 <= rf_mem[rf_radr2];
        end
    end

    // Transaction-level reference model state.
    logic [31:0] m_regs [16] = '{default: 32'h0};
    bit          m_pend     = 1'b0;   // a fetch issued and not yet consumed
    int          m_age      = 0;      // cycles since that fetch issued
    int          m_defer    = 0;      // cycles the waiting fetch lost to writes
    bit          m_rst_prev = 1'b1;
    logic [63:0] sb_q [$];

    // Expectations for the current cycle (initial values describe post-reset state).
    bit exp_req_ready = 1'b0;
    bit exp_wb_ready  = 1'b1;
    bit exp_rf_we     = 1'b0;
    bit exp_rsp_valid = 1'b0;
    bit exp_zero      = 1'b1;
    bit go            = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; also advances the reference model.
    task automatic step(input bit wv, input logic [3:0] wa, input logic [31:0] wd,
                        input bit rv, input logic [3:0] a1, input logic [3:0] a2,
                        input bit rr, input bit rs);
        bit free;
        bit iss;
        bit taken;
        @(posedge clk);
        #1;
        if (m_rst_prev) sb_q.delete();
        reset     = rs;
        wb_valid  = wv;
        wb_adr    = wa;
        wb_data   = wd;
        req_valid = rv;
        req_rs1   = a1;
        req_rs2   = a2;
        rsp_ready = rr;

        exp_rsp_valid = m_pend && (m_age >= 2);
        taken         = exp_rsp_valid && rr;
        free          = !m_pend || taken;
        iss           = rv && free && (!wv || (m_defer == WB_STALL_MAX));
        exp_req_ready = iss;
        exp_wb_ready  = !iss;
        exp_rf_we     = wv && !iss;
        exp_zero      = m_rst_prev;

        if (iss) sb_q.push_back({m_regs[a1], m_regs[a2]});
        if (exp_rf_we) m_regs[wa] = wd;

        if (rs) begin
            m_pend  = 1'b0;
            m_age   = 0;
            m_defer = 0;
        end else begin
            if (m_pend) m_age++;
            if (taken) m_pend = 1'b0;
            if (iss) begin
                m_pend = 1'b1;
                m_age  = 1;
            end
            if (iss || !rv) m_defer = 0;
            else if (free && wv && (m_defer < WB_STALL_MAX)) m_defer++;
        end
        m_rst_prev = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    // Monitor: checks handshake outputs each cycle and pops the scoreboard
    // whenever the DUT should be presenting operands.
    always @(negedge clk) begin
        if (go) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, exp_req_ready});
            chk("wb_ready",  {63'd0, wb_ready},  {63'd0, exp_wb_ready});
            chk("rf_we",     {63'd0, rf_we},     {63'd0, exp_rf_we});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_rsp_valid});
            if (exp_zero) chk("ops_after_reset", {rsp_op1, rsp_op2}, 64'd0);
            if (exp_rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("scoreboard_nonempty", 64'd0, 64'd1);
                end else begin
                    chk("operands", {rsp_op1, rsp_op2}, sb_q[0]);
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        go = 1'b1;
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        idle(2);

        // basic fetch of two written registers
        step(1'b1, 4'd3, 32'h11111111, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 4'd5, 32'h22222222, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0,        1'b1, 4'd3, 4'd5, 1'b1, 1'b0);
        idle(3);

        // write in the cycle right before issue is visible
        step(1'b1, 4'd7, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0,        1'b1, 4'd7, 4'd3, 1'b1, 1'b0);
        idle(3);

        // writes after issue do not disturb captured operands
        step(1'b1, 4'd4, 32'h5, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd4, 32'h9, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd7, 1'b1, 1'b0);
        idle(3);

        // starvation guard: writes and fetches both held high
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'(i), $urandom(), 1'b1, 4'd1, 4'd2, 1'b1, 1'b0);
        idle(3);

        // backpressure with a second request waiting
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'(8 + i), $urandom(), 1'b1, 4'd7, 4'd4, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 4'd4, 1'b1, 1'b0);
        idle(4);

        // reset during FETCH drops the request
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd8, 4'd9, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        idle(5);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            rs = ($urandom_range(0, 149) == 0);
            step(rs ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                 rs ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rs);
        end
        idle(6);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs32_regport.md
# hs32_regport

Register-file access port placed directly upstream of the hs32 dual-port register file. It merges two request streams onto the file's single-cycle port: operand fetches (two source registers) from decode and write-backs from execute. The file cannot read and write in the same cycle, and its read data is registered, so this block owns three jobs: arbitrating between the two streams, sequencing each read, and buffering the fetched operands behind a valid/ready response. Writes win arbitration, with a bounded-starvation guard for reads.

## Interface
Parameters:
- `WB_STALL_MAX`, default 4: consecutive cycles a pending fetch may lose to write-backs before it is forced through.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  write-back request.
- `wb_ready`  out  1  write-back accepted this cycle.
- `wb_adr`  in  4  destination register.
- `wb_data`  in  32  write data.
- `req_valid`  in  1  operand fetch request.
- `req_ready`  out  1  fetch accepted (read issued) this cycle.
- `req_rs1`, `req_rs2`  in  4 each  source registers.
- `rsp_valid`  out  1  operands available.
- `rsp_ready`  in  1  consumer takes operands.
- `rsp_op1`, `rsp_op2`  out  32 each  fetched operands.
- `rf_we`  out  1  to the register file write enable.
- `rf_wadr`  out  4  register file write address, equal to `wb_adr`.
- `rf_din`  out  32  register file write data, equal to `wb_data`.
- `rf_radr1`, `rf_radr2`  out  4 each  register file read addresses.
- `rf_dout1`, `rf_dout2`  in  32 each  register file read data, registered by the file and updated only on cycles where `rf_we`=0.

Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.

## Operation
- FSM states: IDLE, FETCH, RESP.
- Issue condition: `issue` = `req_valid` AND slot free AND (NOT `wb_valid` OR `defer_cnt` == `WB_STALL_MAX`).
  - Slot free means state IDLE, or state RESP AND `rsp_ready`.
- Write condition: `wb_ready` = NOT `issue`. A write is therefore accepted in any state, including FETCH and RESP, whenever no read issues that cycle.
- `rf_we` = `wb_valid` AND `wb_ready`. It is combinational and is never 1 in an issue cycle.
- `req_ready` = `issue`.
- Read addresses: `rf_radr1/2` = `req_rs1/2` in the issue cycle; otherwise they hold the registered copy from the last issue.
- State transitions:
  - IDLE → FETCH on `issue`.
  - FETCH → RESP always, after one cycle. In FETCH, `rsp_op1/2` registers load `rf_dout1/2`.
  - RESP: `rsp_valid`=1.
    - `rsp_ready` AND `issue` → FETCH.
    - `rsp_ready` AND NOT `issue` → IDLE.
    - Otherwise hold.
- Operand semantics: each operand equals the register value as of the end of the cycle before the issue cycle. This includes a write accepted in that preceding cycle. Writes accepted in FETCH or RESP never alter the captured operands.
- `defer_cnt` (width clog2(`WB_STALL_MAX`+1)):
  - Increments, saturating at `WB_STALL_MAX`, in each cycle where `req_valid` AND slot free AND `wb_valid` AND NOT `issue`.
  - Clears on `issue` or when `req_valid`=0.
- Reset values: state IDLE; `rsp_valid` 0; `rsp_op1/2` 0; held read addresses 0; `defer_cnt` 0.
  - With inputs low after reset: `req_ready` 0, `wb_ready` 1, `rf_we` 0.
- Reset mid-operation: any in-flight fetch or response is discarded, and the next cycle is IDLE.

## Timing
- Fetch latency: issue in cycle N, capture in N+1, `rsp_valid`=1 from N+2.
- Back-to-back throughput: one fetch every 2 cycles (RESP→FETCH→RESP).
- Write latency: the write lands in the file at the end of the accept cycle.
- Simultaneous `wb_valid` and `req_valid` with `defer_cnt` < `WB_STALL_MAX`: the write wins.
- Once `defer_cnt` == `WB_STALL_MAX`: the read wins for exactly one cycle (`wb_ready`=0).
- Response handshake: `rsp_op1/2` and `rsp_valid` are stable while `rsp_valid` AND NOT `rsp_ready`.

## Test plan
- **Reset then fetch.** Write r3=0x11111111 and r5=0x22222222. Request rs1=3, rs2=5 at cycle N.
  - `req_ready`=1 at N.
  - `rsp_valid` at N+2 with ops 0x11111111 / 0x22222222.
- **Write just before issue.** Write r7=0xDEADBEEF in cycle N-1, then fetch rs1=7 at N.
  - `rsp_op1`=0xDEADBEEF.
- **Write after issue.** Fetch rs1=4 (old 0x5) at N. Write r4=0x9 in N+1, and again while the response is held.
  - `rsp_op1` stays 0x5.
  - A subsequent fetch of r4 returns 0x9.
- **Starvation guard.** Hold `wb_valid` and `req_valid` high from IDLE with `WB_STALL_MAX`=4.
  - Exactly 4 writes are accepted.
  - Then one cycle with `wb_ready`=0 and `req_ready`=1.
  - Then writes resume.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles with a second request pending.
  - Ops are stable.
  - No second issue occurs.
  - Writes are accepted meanwhile.
  - On `rsp_ready`=1 the second fetch issues in that same cycle.
- **Mid-fetch reset.** Assert `reset` in FETCH.
  - Next cycle: `rsp_valid`=0 and ops = 0.
  - No response is ever produced for the dropped request.
